ext_stage: RTL

EXT_STAGE -- requirements
Module: ext_stage

---
 rtl/ext_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/ext_stage.sv
// Immediate / load-data extension stage followed by a small FIFO output buffer.
// Results are computed at the push edge; the consumer sees only registered state.
module ext_stage #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_word,
    input  logic [OFF_W-1:0]  in_off,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = DATA_W + 1;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    // Returns {data, err}; odd halfword offsets yield zero data with err set.
    function automatic logic [ENT_W-1:0] ext_calc(
        input logic [2:0]        op,
        input logic [IMM_W-1:0]  imm,
        input logic [DATA_W-1:0] word,
        input logic [OFF_W-1:0]  off
    );
        logic signed [DATA_W-1:0] simm;
        logic [15:0]              sh;
        logic signed [7:0]        sbyte;
        logic signed [15:0]       shalf;
        logic [DATA_W-1:0]        data;
        logic                     err;
        simm  = DATA_W'($signed(imm));
        sh    = 16'(word >> {off, 3'b000});
        sbyte = $signed(sh[7:0]);
        shalf = $signed(sh);
        data  = '0;
        err   = 1'b0;
        case (op)
            3'b000: data = simm;
            3'b001: data = DATA_W'(imm);
            3'b010: data = {imm, {(DATA_W - IMM_W){1'b0}}};
            3'b011: data = simm <<< 2;
            3'b100: data = DATA_W'(sbyte);
            3'b101: data = DATA_W'(sh[7:0]);
            3'b110: begin
                if (off[0]) err = 1'b1;
                else        data = DATA_W'(shalf);
            end
            default: begin
                if (off[0]) err = 1'b1;
                else        data = DATA_W'(sh);
            end
        endcase
        return {data, err};
    endfunction

    logic [ENT_W-1:0] ent_p0;
    logic [ENT_W-1:0] buf_p1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             vld_p1;
    logic             push;
    logic             pop;

    // Stage p0: combinational extension of the incoming request
    assign ent_p0 = ext_calc(in_op, in_imm, in_word, in_off);

    assign in_ready = (count < FULL);
    assign vld_p1   = (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = vld_p1 && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage p1: buffered results; payload needs no reset because an empty buffer masks it
    always_ff @(posedge clk) begin
        if (push) buf_p1[wr_ptr] <= ent_p0;
    end

    assign out_valid           = vld_p1;
    assign {out_data, out_err} = vld_p1 ? buf_p1[rd_ptr] : '0;

endmodule
